// File: rtl/sub_4b_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sub_4b_arbiter_pkg
// Shared definitions for the sub_4b arbiter slice: FSM state encoding,
// requester id constants and the unsigned borrow helper.
// Optional build macro used in this slice: SUB_ARB_FIXED_PRIO_EN
// (see rr_arb_2).
// ----------------------------------------------------------------------------
package sub_4b_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // Borrow is derived from an unsigned compare, independent of the
    // subtractor output.
    function automatic logic borrow_of(input logic [3:0] x, input logic [3:0] y);
        return (x < y);
    endfunction

endpackage : sub_4b_arbiter_pkg

// File: rtl/sub_4b_arbiter_if.sv
// ----------------------------------------------------------------------------
// sub_4b_arbiter_if
// Request/response handshake bundle between the two requesters, the
// response consumer and the arbiter.
//   req0_*/req1_* : valid/ready request channels with 4-bit operands x, y
//   rsp_*         : valid/ready response channel (data, borrow, id)
// Modports:
//   master : requester/consumer side (drives requests and rsp_ready)
//   slave  : arbiter side (drives readies and the response)
// ----------------------------------------------------------------------------
interface sub_4b_arbiter_if;

    logic       req0_valid;
    logic       req0_ready;
    logic [3:0] req0_x;
    logic [3:0] req0_y;

    logic       req1_valid;
    logic       req1_ready;
    logic [3:0] req1_x;
    logic [3:0] req1_y;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_borrow;
    logic       rsp_id;

    modport master (
        output req0_valid, req0_x, req0_y,
        output req1_valid, req1_x, req1_y,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_borrow, rsp_id
    );

    modport slave (
        input  req0_valid, req0_x, req0_y,
        input  req1_valid, req1_x, req1_y,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_borrow, rsp_id
    );

endinterface : sub_4b_arbiter_if

// File: rtl/sub_4b_arbiter_rr_arb_2.sv
// ----------------------------------------------------------------------------
// rr_arb_2
// Two-way arbiter. A lone valid requester always wins; under contention the
// requester that did not win last time is chosen (round-robin).
// Build macro: SUB_ARB_FIXED_PRIO_EN -- when defined, requester 0 always
// wins contention and last_grant is ignored (requester 1 can starve).
// Ports:
//   valid0, valid1 : request valids
//   last_grant     : id of the previously granted requester
//   enable         : arbitration allowed this cycle
//   grant_id       : selected requester
//   grant_valid    : a grant is issued this cycle
// ----------------------------------------------------------------------------
module rr_arb_2
    import sub_4b_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic enable,
    output logic grant_id,
    output logic grant_valid
);

`ifdef SUB_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        grant_id    = REQ0;
        grant_valid = enable && (valid0 || valid1);
        if (valid0 && valid1) begin
`ifdef SUB_ARB_FIXED_PRIO_EN
            grant_id = REQ0;
`else
            grant_id = ~last_grant;
`endif
        end else if (valid1) begin
            grant_id = REQ1;
        end
    end

endmodule : rr_arb_2

// File: rtl/sub_4b_arbiter_sub_4b.sv
// ----------------------------------------------------------------------------
// sub_4b
// Combinational 4-bit subtractor: d = (x + ~y + 1) mod 16.
// Ports:
//   x, y : 4-bit unsigned operands
//   d    : 4-bit difference
// ----------------------------------------------------------------------------
module sub_4b (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [3:0] d
);

    // Two's-complement subtract; the carry out is dropped on purpose.
    assign d = x + ~y + 4'd1;

endmodule : sub_4b

// File: rtl/sub_4b_arbiter.sv
// ----------------------------------------------------------------------------
// sub_4b_arbiter
// Shares one sub_4b subtractor between two valid/ready requesters. An
// accepted request is latched, computed in EXEC and presented as a
// registered response in RESP until the consumer takes it.
// Build macro: SUB_ARB_FIXED_PRIO_EN (fixed priority to requester 0).
// Parameters:
//   CNT_W    : width of the saturating ops_done counter (min 1)
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : request/response handshake bundle (slave side)
//   ops_done : completed response handshakes, saturating at all-ones
//   busy     : high whenever the FSM is not IDLE
// ----------------------------------------------------------------------------
module sub_4b_arbiter
    import sub_4b_arbiter_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    sub_4b_arbiter_if.slave  bus,
    output logic [CNT_W-1:0] ops_done,
    output logic             busy
);

    state_t     state;
    logic       last_grant;
    logic [3:0] x_q;
    logic [3:0] y_q;
    logic       id_q;
    logic [3:0] diff;
    logic       grant_id;
    logic       grant_valid;

    rr_arb_2 u_arb (
        .valid0      (bus.req0_valid),
        .valid1      (bus.req1_valid),
        .last_grant  (last_grant),
        .enable      (state == IDLE),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    sub_4b u_sub (
        .x (x_q),
        .y (y_q),
        .d (diff)
    );

    assign bus.req0_ready = grant_valid && (grant_id == REQ0) && bus.req0_valid;
    assign bus.req1_ready = grant_valid && (grant_id == REQ1) && bus.req1_valid;
    assign busy           = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: operand and response registers are reset too, so an op
            // interrupted by reset leaves no stale value visible on rsp_*.
            state          <= IDLE;
            last_grant     <= REQ1;  // requester 0 wins the first contention
            x_q            <= '0;
            y_q            <= '0;
            id_q           <= REQ0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_borrow <= 1'b0;
            bus.rsp_id     <= REQ0;
            ops_done       <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // branch sees the pre-edge values, matching flop behaviour.
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        x_q        <= (grant_id == REQ1) ? bus.req1_x : bus.req0_x;
                        y_q        <= (grant_id == REQ1) ? bus.req1_y : bus.req0_y;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    bus.rsp_data   <= diff;
                    bus.rsp_borrow <= borrow_of(x_q, y_q);
                    bus.rsp_id     <= id_q;
                    bus.rsp_valid  <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        if (ops_done != {CNT_W{1'b1}}) begin
                            ops_done <= ops_done + 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule : sub_4b_arbiter

// File: tb/tb_sub_4b_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sub_4b_arbiter
// Self-checking bench for sub_4b_arbiter (CNT_W=2 so counter saturation is
// reached quickly). Expected values come from a transaction-level model:
// winner selection from the arbitration rule, result from plain arithmetic,
// and a saturating count of completed handshakes.
// ----------------------------------------------------------------------------
module tb_sub_4b_arbiter;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SUB_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] ops_done;
    logic             busy;

    sub_4b_arbiter_if bus ();

    sub_4b_arbiter #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ops_done (ops_done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_last;   // last winner
    int m_count;  // completed handshakes (unsaturated)

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last  = 1'b1;
        m_count = 0;
    endtask

    function automatic int exp_count();
        return (m_count > CNT_MAX) ? CNT_MAX : m_count;
    endfunction

    task automatic check_resp(input string tag, input logic [3:0] d, input logic b, input logic id);
        check({tag, "_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        check({tag, "_data"}, {28'd0, bus.rsp_data}, {28'd0, d});
        check({tag, "_borrow"}, {31'd0, bus.rsp_borrow}, {31'd0, b});
        check({tag, "_id"}, {31'd0, bus.rsp_id}, {31'd0, id});
        check({tag, "_rdy0"}, {31'd0, bus.req0_ready}, 32'd0);
        check({tag, "_rdy1"}, {31'd0, bus.req1_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    // One full transaction: drive requests, check the grant, the response
    // after two cycles, hold it for `stall` cycles of backpressure, then
    // complete the handshake and check the counter.
    task automatic run_op(input string tag, input bit v0, input bit v1,
                          input logic [3:0] x0, input logic [3:0] y0,
                          input logic [3:0] x1, input logic [3:0] y1,
                          input int stall, input bit scramble);
        bit         w;
        logic [3:0] ex, ey, ed;
        logic       eb;
        bus.req0_valid = v0; bus.req0_x = x0; bus.req0_y = y0;
        bus.req1_valid = v1; bus.req1_x = x1; bus.req1_y = y1;
        bus.rsp_ready  = 1'b0;
        #1;
        if (!v0 && !v1) begin
            check({tag, "_idle_rdy0"}, {31'd0, bus.req0_ready}, 32'd0);
            check({tag, "_idle_rdy1"}, {31'd0, bus.req1_ready}, 32'd0);
            tick();
            check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
            return;
        end
        if (v0 && v1) w = FIXED_PRIO ? 1'b0 : ~m_last;
        else          w = v1;
        ex = w ? x1 : x0;
        ey = w ? y1 : y0;
        ed = 4'((int'(ex) - int'(ey) + 16) % 16);
        eb = (int'(ex) < int'(ey));
        check({tag, "_grant0"}, {31'd0, bus.req0_ready}, {31'd0, !w});
        check({tag, "_grant1"}, {31'd0, bus.req1_ready}, {31'd0, w});
        m_last = w;
        tick();  // now in EXEC
        check({tag, "_exec_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_exec_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_exec_rdy"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        if (scramble) begin
            // Operand changes after accept must not reach the result.
            bus.req0_x = 4'($urandom); bus.req0_y = 4'($urandom);
            bus.req1_x = 4'($urandom); bus.req1_y = 4'($urandom);
        end
        tick();  // now in RESP
        check_resp({tag, "_rsp"}, ed, eb, w);
        for (int i = 0; i < stall; i++) begin
            tick();
            check_resp({tag, "_hold"}, ed, eb, w);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        m_count++;
        check({tag, "_done_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_ops_done"}, {30'd0, ops_done}, 32'(exp_count()));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0;
        bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0;
        bus.rsp_ready  = 1'b0;
        rst_n          = 1'b0;
        model_reset();
        #2;

        // Reset state
        check("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_data", {28'd0, bus.rsp_data}, 32'd0);
        check("rst_borrow", {31'd0, bus.rsp_borrow}, 32'd0);
        check("rst_id", {31'd0, bus.rsp_id}, 32'd0);
        check("rst_ops", {30'd0, ops_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;

        // Single op, requester 0: 8 - 9 -> 15 with borrow
        run_op("single", 1, 0, 4'b1000, 4'b1001, 4'h0, 4'h0, 0, 0);

        // Reset in EXEC: immediate clear, no response afterwards
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b1;
        bus.req1_x = 4'd7; bus.req1_y = 4'd2;
        tick();  // accepted, now in EXEC
        bus.req1_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ops", {30'd0, ops_done}, 32'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_norsp", {31'd0, bus.rsp_valid}, 32'd0);
        end

        // Contention: both valid every op, grants 0,1,0,1 (or all 0 fixed)
        for (int i = 0; i < 4; i++) begin
            run_op("contend", 1, 1, 4'b1101, 4'b0110, 4'b0101, 4'b0101, 0, 0);
        end

        // Equal/zero operands
        run_op("zero_eq", 1, 0, 4'b0000, 4'b0000, 4'h0, 4'h0, 0, 0);
        run_op("zero_lt", 0, 1, 4'h0, 4'h0, 4'b0000, 4'b0001, 0, 0);

        // Backpressure for 5 cycles
        run_op("bpress", 1, 1, 4'd3, 4'd12, 4'd9, 4'd4, 5, 1);

        // No valid requester: nothing happens
        run_op("novalid", 0, 0, 4'd1, 4'd2, 4'd3, 4'd4, 0, 0);

        // Counter saturation from a fresh reset: 1,2,3,3,3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_op("sat", 1, 0, 4'(i), 4'd2, 4'h0, 4'h0, 0, 0);
        end

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            run_op("rand", 1'($urandom), 1'($urandom),
                   4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                   int'($urandom_range(0, 3)), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sub_4b_arbiter
